// File: rtl/multi_cycle_controller_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V controller:
// FSM states, opcodes, ALU control codes and datapath mux selects.
package multi_cycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_TRAP
    } state_t;

    // What the FSM asks of the ALU; FUNCT defers to the instruction fields.
    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } alu_op_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/multi_cycle_controller_alu_decoder.sv
// Maps the FSM's ALU request plus funct3/funct7 fields to an ALUControl code.
module alu_decoder
    import multi_cycle_controller_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    // Subtraction only for R-type with funct7b5; addi with bit 30 set stays add.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle controller FSM: sequences fetch, decode, memory, execute and
// write-back steps, and traps permanently on an unknown opcode until reset.
module multi_cycle_controller
    import multi_cycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       MemReq,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       InstrDone,
    output logic       Illegal
);

    state_t  state;
    alu_op_t alu_op;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (MemReady) state <= S_DECODE;
                S_DECODE: begin
                    case (Op)
                        OP_LOAD, OP_STORE: state <= S_MEMADR;
                        OP_RTYPE:          state <= S_EXECR;
                        OP_ITYPE:          state <= S_EXECI;
                        OP_BEQ:            state <= S_BEQ;
                        OP_JAL:            state <= S_JAL;
                        default:           state <= S_TRAP;
                    endcase
                end
                S_MEMADR:   state <= Op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (MemReady) state <= S_MEMWB;
                S_MEMWRITE: if (MemReady) state <= S_FETCH;
                S_EXECR, S_EXECI, S_JAL: state <= S_ALUWB;
                S_MEMWB, S_ALUWB, S_BEQ: state <= S_FETCH;
                S_TRAP:     state <= S_TRAP;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Outputs decode from the state register; the few that follow MemReady or
    // Zero within the cycle are gated here, and everything drops while in reset.
    always_comb begin
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        MemReq    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_REG;
        alu_op    = ALUOP_ADD;
        InstrDone = 1'b0;
        Illegal   = 1'b0;
        if (rst) begin
            case (state)
                S_FETCH: begin
                    MemReq    = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALU;
                    IRWrite   = MemReady;
                    PCWrite   = MemReady;
                end
                S_DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMADR: begin
                    ALUSrcA = SRCA_REG;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMREAD: begin
                    MemReq = 1'b1;
                    AdrSrc = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = RES_DATA;
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_MEMWRITE: begin
                    MemReq    = 1'b1;
                    AdrSrc    = 1'b1;
                    MemWrite  = 1'b1;
                    InstrDone = MemReady;
                end
                S_EXECR: begin
                    ALUSrcA = SRCA_REG;
                    ALUSrcB = SRCB_REG;
                    alu_op  = ALUOP_FUNCT;
                end
                S_EXECI: begin
                    ALUSrcA = SRCA_REG;
                    ALUSrcB = SRCB_IMM;
                    alu_op  = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_BEQ: begin
                    ALUSrcA   = SRCA_REG;
                    ALUSrcB   = SRCB_REG;
                    alu_op    = ALUOP_SUB;
                    PCWrite   = Zero;
                    InstrDone = 1'b1;
                end
                S_JAL: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_FOUR;
                    PCWrite = 1'b1;
                end
                S_TRAP:  Illegal = 1'b1;
                default: Illegal = 1'b0;
            endcase
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (Op[5]),
        .alu_control (ALUControl)
    );

endmodule
